ahb_slave: RTL and testbench

- AHB-Lite slave that bridges AHB transfers onto a simple single-port memory request interface (valid/ready, read-valid return).
- Sits between the AHB interconnect (slave mux provides i_hready and receives o_hreadyout/o_hresp/o_hrdata) and a memory or register block.
- Pipelined: captures the address phase, then issues one memory request per transfer during the AHB data phase.

---
 rtl/ahb_slave.sv | 195 +++++++++++++++++++
 tb/tb_ahb_slave.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave.sv
// ---------------------------------------------------------------------------
// ahb_slave
//
// Bridges AHB-Lite transfers onto a simple single-port memory request
// interface. The address phase is registered; during the following data
// phase exactly one memory request is presented (o_valid) and held until the
// memory answers with i_ready. Wait states are inserted on the AHB side by
// passing i_ready straight through to o_hreadyout. Back-to-back transfers
// overlap the data phase of one transfer with the address phase of the next,
// so a stream of transfers runs without bubbles.
//
// Optional feature (macro AHB_SLAVE_ERR_RESP_EN):
//   When defined, an accepted transfer whose i_hsize is wider than the data
//   bus, or whose address is not aligned to i_hsize, is not forwarded to
//   memory. The slave answers it with the two-cycle AHB ERROR response.
//   When undefined, i_hsize is ignored and o_hresp is always OKAY.
//
// Parameters:
//   DATA_WIDTH  width of hwdata/hrdata and the memory data buses
//   ADDR_WIDTH  width of haddr and the memory address
//
// Ports:
//   i_clk_ahb    AHB clock, rising-edge active
//   i_rstn_ahb   asynchronous active-low reset
//   i_hready     bus-level HREADY (previous transfer complete)
//   i_hmastlock  locked transfer (ignored)
//   i_htrans     1 = active transfer (NONSEQ/SEQ), 0 = IDLE
//   i_hprot      protection control (ignored)
//   i_hburst     burst type (ignored, every beat is a single)
//   i_hsize      transfer size (only used by the optional feature)
//   i_hwrite     1 = write, 0 = read
//   i_haddr      transfer address
//   i_hwdata     write data (data phase)
//   i_hselx      slave select
//   i_ready      memory accepts/completes the current request
//   i_rd_valid   memory read data valid
//   i_rd_data    memory read data
//   o_hreadyout  slave ready, 0 inserts wait states
//   o_hresp      0 = OKAY, 1 = ERROR
//   o_hrdata     read data to the master
//   o_valid      memory request valid
//   o_rd0_wr1    memory request direction (0 read, 1 write)
//   o_wr_data    memory write data
//   o_addr       memory address
// ---------------------------------------------------------------------------
module ahb_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk_ahb,
    input  logic                  i_rstn_ahb,
    input  logic                  i_hready,
    input  logic                  i_hmastlock,
    input  logic                  i_htrans,
    input  logic [3:0]            i_hprot,
    input  logic [2:0]            i_hburst,
    input  logic [2:0]            i_hsize,
    input  logic                  i_hwrite,
    input  logic [ADDR_WIDTH-1:0] i_haddr,
    input  logic [DATA_WIDTH-1:0] i_hwdata,
    input  logic                  i_hselx,
    input  logic                  i_ready,
    input  logic                  i_rd_valid,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_hreadyout,
    output logic                  o_hresp,
    output logic [DATA_WIDTH-1:0] o_hrdata,
    output logic                  o_valid,
    output logic                  o_rd0_wr1,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic [ADDR_WIDTH-1:0] o_addr
);

    // ST_DATA is the "pending" data phase. The error states are only
    // reachable when the error-response feature is compiled in.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic                    write_reg;
    logic [DATA_WIDTH-1:0]   hrdata_reg;
    logic                    accept;
    logic                    xfer_err;

    assign accept = i_hselx & i_htrans & i_hready;

`ifdef AHB_SLAVE_ERR_RESP_EN
    // Largest legal hsize is log2 of the bus width in bytes.
    localparam int              SIZE_BITS = $clog2(DATA_WIDTH / 8);
    localparam logic [2:0]      MAX_HSIZE = 3'(SIZE_BITS);

    // Low address bits that must be zero for a transfer of 2**hsize bytes.
    logic [ADDR_WIDTH-1:0] align_mask;
    assign align_mask = ~({ADDR_WIDTH{1'b1}} << i_hsize);
    assign xfer_err   = (i_hsize > MAX_HSIZE) || ((i_haddr & align_mask) != '0);

    logic unused_inputs;
    assign unused_inputs = &{1'b0, i_hmastlock, i_hprot, i_hburst};
`else
    assign xfer_err = 1'b0;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, i_hmastlock, i_hprot, i_hburst, i_hsize};
`endif

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
        if (!i_rstn_ahb) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // The first ERROR cycle always advances: it drives hreadyout low, so the
    // bus cannot complete anything on that edge. Every other state follows
    // the address-phase handshake: a new accepted transfer starts a data
    // phase (or an error response), and a bus-ready edge with nothing
    // accepted returns to idle. With hready low the current phase is held.
    always_comb begin
        state_next = state_reg;
        if (state_reg == ST_ERR1) begin
            state_next = ST_ERR2;
        end else if (accept) begin
            state_next = xfer_err ? ST_ERR1 : ST_DATA;
        end else if (i_hready) begin
            state_next = ST_IDLE;
        end
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        o_valid     = 1'b0;
        o_hreadyout = 1'b1;
        o_hresp     = 1'b0;
        case (state_reg)
            ST_DATA: begin
                o_valid     = 1'b1;
                o_hreadyout = i_ready;
            end
            ST_ERR1: begin
                o_hresp     = 1'b1;
                o_hreadyout = 1'b0;
            end
            ST_ERR2: begin
                o_hresp     = 1'b1;
                o_hreadyout = 1'b1;
            end
            default: begin
                o_valid     = 1'b0;
                o_hreadyout = 1'b1;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Address-phase capture and read-data hold register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
        if (!i_rstn_ahb) begin
            addr_reg   <= '0;
            write_reg  <= 1'b0;
            hrdata_reg <= '0;
        end else begin
            if (accept) begin
                addr_reg  <= i_haddr;
                write_reg <= i_hwrite;
            end
            if (i_rd_valid) begin
                hrdata_reg <= i_rd_data;
            end
        end
    end

    // Memory returns read data in the completing cycle, so it is forwarded
    // combinationally; the hold register keeps it visible afterwards.
    assign o_hrdata  = i_rd_valid ? i_rd_data : hrdata_reg;
    assign o_addr    = addr_reg;
    assign o_rd0_wr1 = write_reg;
    assign o_wr_data = i_hwdata;

endmodule

// File: tb/tb_ahb_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave
//
// Directed bench for ahb_slave. A master task drives pipelined AHB transfers
// from a table; as each transfer enters its data phase the hand-computed
// expected memory transaction (direction, address, data, wait-state count)
// is pushed onto a queue. A monitor on the falling clock edge pops and
// compares whenever the memory handshake completes (o_valid & i_ready).
// i_hready is looped back from o_hreadyout, modelling a single-slave bus.
// ---------------------------------------------------------------------------
module tb_ahb_slave;

    localparam int DW = 32;
    localparam int AW = 32;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            stall;
    } xfer_t;

    logic          clk;
    logic          rstn;
    logic          hready;
    logic          hmastlock;
    logic          htrans;
    logic [3:0]    hprot;
    logic [2:0]    hburst;
    logic [2:0]    hsize;
    logic          hwrite;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hwdata;
    logic          hselx;
    logic          ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          hreadyout;
    logic          hresp;
    logic [DW-1:0] hrdata;
    logic          valid;
    logic          rd0_wr1;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] addr;

    int n_vec = 0;
    int n_err = 0;
    int stall_cnt = 0;

    xfer_t seq_q[$];
    xfer_t exp_q[$];

    ahb_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk_ahb   (clk),
        .i_rstn_ahb  (rstn),
        .i_hready    (hready),
        .i_hmastlock (hmastlock),
        .i_htrans    (htrans),
        .i_hprot     (hprot),
        .i_hburst    (hburst),
        .i_hsize     (hsize),
        .i_hwrite    (hwrite),
        .i_haddr     (haddr),
        .i_hwdata    (hwdata),
        .i_hselx     (hselx),
        .i_ready     (ready),
        .i_rd_valid  (rd_valid),
        .i_rd_data   (rd_data),
        .o_hreadyout (hreadyout),
        .o_hresp     (hresp),
        .o_hrdata    (hrdata),
        .o_valid     (valid),
        .o_rd0_wr1   (rd0_wr1),
        .o_wr_data   (wr_data),
        .o_addr      (addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-slave interconnect: bus HREADY is this slave's HREADYOUT.
    assign hready = hreadyout;

    // Memory model: reads complete in the cycle i_ready is high. Contents are
    // address-as-data except location 0xB.
    always_comb begin
        rd_valid = 1'b0;
        rd_data  = '0;
        if (valid && !rd0_wr1 && ready) begin
            rd_valid = 1'b1;
            rd_data  = (addr == 32'h0000_000B) ? 32'hBBBB_BBBB : addr;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // -----------------------------------------------------------------------
    // Monitor / scoreboard
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rstn) begin
            stall_cnt = 0;
        end else if (valid && !ready) begin
            stall_cnt++;
            check("wait_hreadyout", {31'd0, hreadyout}, 32'd0);
        end else if (valid && ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_request", 32'd1, 32'd0);
            end else begin
                xfer_t e;
                e = exp_q.pop_front();
                check("req_dir", {31'd0, rd0_wr1}, {31'd0, e.wr});
                check("req_addr", addr, e.addr);
                check(e.wr ? "wr_data" : "hrdata", e.wr ? wr_data : hrdata, e.data);
                check("done_hreadyout", {31'd0, hreadyout}, 32'd1);
                check("wait_cycles", stall_cnt, e.stall);
                check("hresp", {31'd0, hresp}, 32'd0);
            end
            stall_cnt = 0;
        end
    end

    // -----------------------------------------------------------------------
    // Master: runs seq_q as a back-to-back pipelined stream.
    // -----------------------------------------------------------------------
    task automatic run_seq();
        int   a = 0;
        int   cur = -1;
        int   stall_left = 0;
        int   guard = 0;
        int   n = seq_q.size();
        logic hr;
        while ((a < n || cur >= 0) && guard < 200) begin
            guard++;
            if (a < n) begin
                hselx  = 1'b1;
                htrans = 1'b1;
                haddr  = seq_q[a].addr;
                hwrite = seq_q[a].wr;
            end else begin
                htrans = 1'b0;
                haddr  = '0;
                hwrite = 1'b0;
            end
            hwdata = (cur >= 0 && seq_q[cur].wr) ? seq_q[cur].data : '0;
            ready  = (stall_left > 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            hr = hreadyout;
            @(posedge clk);
            #1;
            if (hr) begin
                if (a < n) begin
                    cur        = a;
                    stall_left = seq_q[a].stall;
                    exp_q.push_back(seq_q[a]);
                    a++;
                end else begin
                    cur = -1;
                end
            end else if (stall_left > 0) begin
                stall_left--;
            end
        end
        if (guard >= 200) check("seq_timeout", 32'd1, 32'd0);
        htrans = 1'b0;
        hwrite = 1'b0;
        haddr  = '0;
        hwdata = '0;
        ready  = 1'b1;
        seq_q.delete();
    endtask

    task automatic add(input logic wr, input logic [31:0] a, input logic [31:0] d, input int st);
        xfer_t t;
        t.wr = wr; t.addr = a; t.data = d; t.stall = st;
        seq_q.push_back(t);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk); #1;
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        rstn = 1'b0; hmastlock = 1'b0; htrans = 1'b0; hprot = 4'h3;
        hburst = 3'd0; hsize = 3'd2; hwrite = 1'b0; haddr = '0;
        hwdata = 32'h1234_5678; hselx = 1'b0; ready = 1'b1;

        // Reset state
        #12;
        check("rst_hreadyout", {31'd0, hreadyout}, 32'd1);
        check("rst_hresp", {31'd0, hresp}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_dir", {31'd0, rd0_wr1}, 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_hrdata", hrdata, 32'd0);
        check("rst_wr_data_follows", wr_data, 32'h1234_5678);
        @(negedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Single write
        add(1'b1, 32'h0A, 32'hAAAA_AAAA, 0);
        run_seq();
        drain();

        // Write/read/write pipeline
        add(1'b1, 32'h0A, 32'hAAAA_AAAA, 0);
        add(1'b0, 32'h0B, 32'hBBBB_BBBB, 0);
        add(1'b1, 32'h0C, 32'hCCCC_CCCC, 0);
        run_seq();
        drain();

        // Write burst, one wait state on 0x38
        add(1'b1, 32'h38, 32'h38, 1);
        add(1'b1, 32'h3C, 32'h3C, 0);
        add(1'b1, 32'h30, 32'h30, 0);
        add(1'b1, 32'h34, 32'h34, 0);
        run_seq();
        drain();

        // Read burst, one wait state on 0x28
        add(1'b0, 32'h20, 32'h20, 0);
        add(1'b0, 32'h24, 32'h24, 0);
        add(1'b0, 32'h28, 32'h28, 1);
        add(1'b0, 32'h2C, 32'h2C, 0);
        run_seq();
        drain();

        // Idle and deselect: no request, ready high, read data held
        for (int i = 0; i < 4; i++) begin
            hselx  = (i < 2) ? 1'b0 : 1'b1;
            htrans = (i < 2) ? 1'b1 : 1'b0;
            haddr  = 32'h0000_0050;
            hwrite = 1'b0;
            @(posedge clk); #1;
            check("idle_valid", {31'd0, valid}, 32'd0);
            check("idle_hreadyout", {31'd0, hreadyout}, 32'd1);
            check("idle_hrdata_hold", hrdata, 32'h2C);
            check("idle_addr_hold", addr, 32'h2C);
        end
        hselx = 1'b0; htrans = 1'b0; haddr = '0;

        // Reset in the middle of a wait state
        hselx = 1'b1; htrans = 1'b1; haddr = 32'h40; hwrite = 1'b0; ready = 1'b1;
        @(posedge clk); #1;
        htrans = 1'b0; haddr = '0; ready = 1'b0;
        #2;
        check("midrst_pre_valid", {31'd0, valid}, 32'd1);
        check("midrst_pre_hreadyout", {31'd0, hreadyout}, 32'd0);
        rstn = 1'b0;
        #1;
        check("midrst_valid", {31'd0, valid}, 32'd0);
        check("midrst_hreadyout", {31'd0, hreadyout}, 32'd1);
        check("midrst_hrdata", hrdata, 32'd0);
        check("midrst_addr", addr, 32'd0);
        @(negedge clk); #1;
        rstn = 1'b1; ready = 1'b1; hselx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_valid", {31'd0, valid}, 32'd0);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
